uart_tx_fifo: RTL

//  Parametrised transmit buffer between the host write port and the UART transmitter.

---
 rtl/uart_tx_fifo.sv | 101 ++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO between the host write port and the UART transmitter.
// First-word-fall-through head, occupancy count, almost-full, flush and sticky error flags.
module uart_tx_fifo #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AW       = 4,
  parameter int unsigned AF_LEVEL = 12
) (
  input  logic              clk_fifo_tx,
  input  logic              rst_fifo_tx_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              flush,
  output logic              tx_valid,
  input  logic              next_frame,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam logic [AW:0] CntFull = (AW+1)'(DEPTH);
  localparam logic [AW:0] CntAf   = (AW+1)'(AF_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_pt_q, wr_pt_d;
  logic [AW-1:0]     rd_pt_q, rd_pt_d;
  logic [AW:0]       count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              push, pop;

  // Full/empty are evaluated on the registered count, so a push against a
  // full FIFO is rejected even if a pop happens in the same cycle.
  assign push = wr_en & ~full & ~flush;
  assign pop  = next_frame & ~empty & ~flush;

  always_comb begin
    wr_pt_d = wr_pt_q;
    rd_pt_d = rd_pt_q;
    count_d = count_q;
    if (flush) begin
      wr_pt_d = '0;
      rd_pt_d = '0;
      count_d = '0;
    end else begin
      if (push) wr_pt_d = wr_pt_q + 1'b1;
      if (pop)  rd_pt_d = rd_pt_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Setting an error takes priority over clearing it in the same cycle.
  always_comb begin
    overflow_d  = overflow_q & ~err_clr;
    underflow_d = underflow_q & ~err_clr;
    if (wr_en & full)       overflow_d  = 1'b1;
    if (next_frame & empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk_fifo_tx) begin
    if (!rst_fifo_tx_n) begin
      wr_pt_q     <= '0;
      rd_pt_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_pt_q     <= wr_pt_d;
      rd_pt_q     <= rd_pt_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_fifo_tx) begin
    if (rst_fifo_tx_n && push) mem_q[wr_pt_q] <= data_in;
  end

  always_comb begin
    count       = count_q;
    empty       = (count_q == '0);
    full        = (count_q == CntFull);
    almost_full = (count_q >= CntAf);
    tx_valid    = ~empty;
    data_out    = empty ? '0 : mem_q[rd_pt_q];
    overflow    = overflow_q;
    underflow   = underflow_q;
  end

endmodule
